seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
Receive-side counterpart of the team's BCD-to-seven-segment path. The block monitors a time-multiplexed, active-low seven-segment bus (anodes plus cathodes) and recovers the 4-bit code shown on each digit. It sits in test and loopback logic, checking what the display drivers actually emit. Per-digit registers are updated only after the bus has been stable for a programmable number of cycles, which rejects scan transitions and ghosting.

Parameters:
NUM_DIGITS, 4, number of anode lines and digit slots (2..8).
STABLE_CYCLES, 8, consecutive identical samples required before a commit (2..255).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
an  in  NUM_DIGITS  anode enables, active-low; bit i selects digit i.
segs  in  7  cathodes, active-low; bit6=g … bit0=a.
clr_err  in  1  synchronous clear of bad_pattern.
digits  out  4*NUM_DIGITS  recovered codes; digit i is at [4i+3:4i].
digit_valid  out  NUM_DIGITS  set when digit i holds a committed code.
update  out  1  one-cycle pulse on every commit (code or blank).
update_idx  out  3  index of the digit committed by the current update.
bad_pattern  out  1  sticky flag: an unrecognised pattern was committed.

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchronisers 0, FSM in IDLE, counter 0.
- Synchronisation: an and segs pass through a 2-flop synchroniser. The sample S = {idx, segs} is taken from the second flop.
- Active digit: exactly one an bit low gives a valid idx. Zero or multiple low bits is "no digit".
- States:
  - IDLE: no digit. Go to SETTLE when a valid idx appears; counter=1.
  - SETTLE: if S equals the previous S, increment the counter. If S differs, stay in SETTLE with counter=1. If there is no digit, go to IDLE. When the counter reaches STABLE_CYCLES, commit and go to HELD.
  - HELD: no further commits while S is unchanged. Any change goes to SETTLE (counter=1) or to IDLE.
- Commit decode (segs hex → code):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 08→A, 03→B, 5F→C, 4F→D, 7D→E, 07→F.
- Commit actions:
  - Valid code: digits[idx]←code, digit_valid[idx]←1, update=1, update_idx=idx.
  - 7F (blank): digits[idx] unchanged, digit_valid[idx]←0, update=1.
  - Any other pattern: bad_pattern←1, no update, digit registers unchanged.
- Latency: if the pins become stable before clock edge E0, update is high in the cycle following edge E0+(STABLE_CYCLES+1). With the default of 8, update is high in cycle 10.
- update is registered and lasts exactly 1 cycle per commit.
- update_idx holds its last value between pulses. Upper bits beyond clog2(NUM_DIGITS) are 0.
- clr_err clears bad_pattern next cycle. If clr_err coincides with a bad commit, the set wins.
- Reset mid-SETTLE discards the pending commit.

Optional Feature:
SEG_BAD_COUNT_EN
- Defined: adds output bad_count[7:0]. It increments on each bad-pattern commit, saturates at 255, and is cleared by clr_err (a simultaneous increment wins, giving 1). Reset value 0.
- Undefined: the port and counter are absent. bad_pattern alone reports errors.

Test Plan:
- Reset, an=1111, segs=7F for 50 cycles → all outputs 0, no update.
- an=1110, segs=24 held 20 cycles (STABLE_CYCLES=8) → single update in cycle 10, update_idx=0, digits[3:0]=2, digit_valid=0001.
- Scan idx0..3 for 16 cycles each with 30, 19, 12, 07 → four updates (idx 0, 1, 2, 3), digits=16'hF543, digit_valid=1111.
- Scan with 5-cycle dwell per digit → no update, digits and digit_valid remain 0.
- an=1101, segs=55 held 12 cycles → bad_pattern=1, no update, digits unchanged. clr_err pulse → bad_pattern=0. With SEG_BAD_COUNT_EN defined, bad_count goes 1 then 0.
- After a valid digit 2, apply blank 7F on idx2 → update, digit_valid[2]=0. Then apply an=1100 → IDLE, no commit. Assert rst_n low during SETTLE → all outputs 0 asynchronously.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Recovers per-digit 4-bit codes from a multiplexed active-low seven-segment bus.
// Optional macro SEG_BAD_COUNT_EN adds a saturating bad-pattern counter output.

module seg7_digit_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_code,
  input  logic       wr_blank,
  input  logic [3:0] code,
  output logic [3:0] digit,
  output logic       valid
);
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;

  always_comb begin
    digit_d = digit_q;
    valid_d = valid_q;
    if (wr_code) begin
      digit_d = code;
      valid_d = 1'b1;
    end else if (wr_blank) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      valid_q <= 1'b0;
    end else begin
      digit_q <= digit_d;
      valid_q <= valid_d;
    end
  end

  assign digit = digit_q;
  assign valid = valid_q;
endmodule

module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              segs,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [2:0]              update_idx,
`ifdef SEG_BAD_COUNT_EN
  output logic [7:0]              bad_count,
`endif
  output logic                    bad_pattern
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  // {ok, blank, code}
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = {2'b10, 4'h0};
      7'h79: seg_decode = {2'b10, 4'h1};
      7'h24: seg_decode = {2'b10, 4'h2};
      7'h30: seg_decode = {2'b10, 4'h3};
      7'h19: seg_decode = {2'b10, 4'h4};
      7'h12: seg_decode = {2'b10, 4'h5};
      7'h02: seg_decode = {2'b10, 4'h6};
      7'h78: seg_decode = {2'b10, 4'h7};
      7'h00: seg_decode = {2'b10, 4'h8};
      7'h10: seg_decode = {2'b10, 4'h9};
      7'h08: seg_decode = {2'b10, 4'hA};
      7'h03: seg_decode = {2'b10, 4'hB};
      7'h5F: seg_decode = {2'b10, 4'hC};
      7'h4F: seg_decode = {2'b10, 4'hD};
      7'h7D: seg_decode = {2'b10, 4'hE};
      7'h07: seg_decode = {2'b10, 4'hF};
      7'h7F: seg_decode = {2'b01, 4'h0};
      default: seg_decode = 6'b0;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0] an_m_q, an_s_q, an_p_q;
  logic [6:0]            segs_m_q, segs_s_q, segs_p_q;
  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  update_q, update_d;
  logic [2:0]            update_idx_q, update_idx_d;
  logic                  bad_q, bad_d;
  logic [3:0]            nlow;
  logic [IW-1:0]         idx;
  logic                  has_dig, same, commit;
  logic [5:0]            dec;
  logic                  wr_code, wr_blank, bad_hit;

  // Two-flop synchroniser; the previous sample feeds the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m_q   <= '0;
      an_s_q   <= '0;
      an_p_q   <= '0;
      segs_m_q <= '0;
      segs_s_q <= '0;
      segs_p_q <= '0;
    end else begin
      an_m_q   <= an;
      an_s_q   <= an_m_q;
      an_p_q   <= an_s_q;
      segs_m_q <= segs;
      segs_s_q <= segs_m_q;
      segs_p_q <= segs_s_q;
    end
  end

  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s_q[i]) begin
        nlow = nlow + 4'd1;
        idx  = IW'(i);
      end
    end
    has_dig = (nlow == 4'd1);
    same    = ({an_s_q, segs_s_q} == {an_p_q, segs_p_q});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (has_dig) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!has_dig) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == STABLE_C) begin
            commit  = 1'b1;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!has_dig) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dec          = seg_decode(segs_s_q);
    wr_code      = commit & dec[5];
    wr_blank     = commit & dec[4];
    bad_hit      = commit & ~dec[5] & ~dec[4];
    update_d     = wr_code | wr_blank;
    update_idx_d = update_d ? 3'(idx) : update_idx_q;
    bad_d        = bad_q;
    if (bad_hit)      bad_d = 1'b1;
    else if (clr_err) bad_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      update_q     <= update_d;
      update_idx_q <= update_idx_d;
      bad_q        <= bad_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    logic sel;
    assign sel = (idx == IW'(g));
    seg7_digit_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_code  (wr_code & sel),
      .wr_blank (wr_blank & sel),
      .code     (dec[3:0]),
      .digit    (digits[4*g +: 4]),
      .valid    (digit_valid[g])
    );
  end

`ifdef SEG_BAD_COUNT_EN
  logic [7:0] bad_cnt_q, bad_cnt_d;

  // A bad commit coinciding with clr_err restarts the count at 1.
  always_comb begin
    bad_cnt_d = bad_cnt_q;
    if (bad_hit) begin
      if (clr_err)                bad_cnt_d = 8'd1;
      else if (bad_cnt_q != 8'hFF) bad_cnt_d = bad_cnt_q + 8'd1;
    end else if (clr_err) begin
      bad_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bad_cnt_q <= '0;
    else        bad_cnt_q <= bad_cnt_d;
  end

  assign bad_count = bad_cnt_q;
`endif

  assign update      = update_q;
  assign update_idx  = update_idx_q;
  assign bad_pattern = bad_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: expected commits are queued as the
// bus is driven and checked when update pulses.

module tb_seg7_scan_capture;
  localparam int ND = 4;

  logic            clk, rst_n, clr_err;
  logic [ND-1:0]   an;
  logic [6:0]      segs;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            update, bad_pattern;
  logic [2:0]      update_idx;
`ifdef SEG_BAD_COUNT_EN
  logic [7:0]      bad_count;
`endif

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .segs        (segs),
    .clr_err     (clr_err),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .update_idx  (update_idx),
`ifdef SEG_BAD_COUNT_EN
    .bad_count   (bad_count),
`endif
    .bad_pattern (bad_pattern)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       blank;
    logic [3:0] code;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic dwell(input logic [ND-1:0] a, input logic [6:0] s, input int n);
    an   = a;
    segs = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int i, input logic blank, input logic [3:0] code);
    exp_t e;
    e.idx   = 3'(i);
    e.blank = blank;
    e.code  = code;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && update) begin
      if (sb.size() == 0) begin
        chk("unexpected_update", {29'd0, update_idx}, 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("update_idx", {29'd0, update_idx}, {29'd0, e.idx});
        chk("commit_valid", {31'd0, digit_valid[e.idx]}, {31'd0, ~e.blank});
        if (!e.blank)
          chk("commit_code", {28'd0, digits[4*e.idx +: 4]}, {28'd0, e.code});
      end
    end
  end

  initial begin
    logic [6:0] pats [4];
    pats[0] = 7'h30; pats[1] = 7'h19; pats[2] = 7'h12; pats[3] = 7'h07;
    rst_n = 1'b0; clr_err = 1'b0; an = '1; segs = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle bus: nothing commits
    dwell(4'b1111, 7'h7F, 50);
    chk("rst_digits", {16'd0, digits}, 32'd0);
    chk("rst_valid", {28'd0, digit_valid}, 32'd0);
    chk("rst_upd_idx", {29'd0, update_idx}, 32'd0);
    chk("rst_bad", {31'd0, bad_pattern}, 32'd0);

    // Fast scan: dwell too short to ever commit
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < ND; i++) dwell(~(4'b0001 << i), pats[i], 5);
    dwell(4'b1111, 7'h7F, 12);
    chk("fast_digits", {16'd0, digits}, 32'd0);
    chk("fast_valid", {28'd0, digit_valid}, 32'd0);

    // Single digit latency
    push(0, 1'b0, 4'h2);
    an = 4'b1110; segs = 7'h24;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (update && lat == 0) lat = n;
    end
    chk("latency", lat, 10);
    chk("d0_digit", {28'd0, digits[3:0]}, 32'h2);
    chk("d0_valid", {28'd0, digit_valid}, 32'h1);

    // Slow scan commits every digit
    for (int i = 0; i < ND; i++) begin
      push(i, 1'b0, (i == 3) ? 4'hF : 4'(i + 3));
      dwell(~(4'b0001 << i), pats[i], 16);
    end
    dwell(4'b1111, 7'h7F, 4);
    chk("scan_digits", {16'd0, digits}, 32'hF543);
    chk("scan_valid", {28'd0, digit_valid}, 32'hF);

    // Unrecognised pattern
    dwell(4'b1101, 7'h55, 12);
    dwell(4'b1111, 7'h7F, 2);
    chk("bad_set", {31'd0, bad_pattern}, 32'd1);
    chk("bad_digits", {16'd0, digits}, 32'hF543);
`ifdef SEG_BAD_COUNT_EN
    chk("bad_cnt1", {24'd0, bad_count}, 32'd1);
`endif
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("bad_clr", {31'd0, bad_pattern}, 32'd0);
`ifdef SEG_BAD_COUNT_EN
    chk("bad_cnt0", {24'd0, bad_count}, 32'd0);
`endif

    // Blank on digit 2, then two anodes low (no digit)
    push(2, 1'b1, 4'h0);
    dwell(4'b1011, 7'h7F, 14);
    dwell(4'b1100, 7'h02, 20);
    chk("blank_valid", {28'd0, digit_valid}, 32'hB);
    chk("blank_keep", {28'd0, digits[11:8]}, 32'h5);
    chk("blank_idx", {29'd0, update_idx}, 32'd2);

    // Reset while settling
    dwell(4'b1110, 7'h24, 6);
    rst_n = 1'b0;
    #1;
    chk("arst_digits", {16'd0, digits}, 32'd0);
    chk("arst_valid", {28'd0, digit_valid}, 32'd0);
    chk("arst_upd", {31'd0, update}, 32'd0);
    chk("arst_idx", {29'd0, update_idx}, 32'd0);
    an = '1; segs = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dwell(4'b1111, 7'h7F, 20);
    chk("post_rst_digits", {16'd0, digits}, 32'd0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
